// File: rtl/iosys_cmd_engine.sv
// iosys_cmd_engine
//   Byte-level command engine for the companion-MCU link. It decodes host
//   commands from a UART RX byte strobe and drives ROM loading, the core
//   config word, overlay text writes and USB HID pad state. It also emits
//   framed responses and rate-limited joypad reports on a valid/ready TX
//   byte interface.
//
// Ports
//   clk, resetn              clock, synchronous active-low reset
//   rx_data/rx_valid         received byte, one-cycle strobe
//   tx_data/tx_valid/ready   transmit byte handshake
//   joy_in                   live pad state, pad k at [16k+15:16k]
//   hid_out                  USB HID pad state, same packing
//   core_config              32-bit config word
//   overlay                  OSD enable
//   rom_loading              ROM loading state byte
//   rom_do/rom_do_valid      ROM byte stream
//   char_we/char_x/y/d       overlay text write strobe and payload
//   err_timeout              one-cycle pulse when a command stalls
module iosys_cmd_engine #(
  parameter int unsigned NUM_PADS     = 2,
  parameter int unsigned LEN_BYTES    = 3,
  parameter logic [15:0] CORE_ID      = 16'd1,
  parameter int unsigned COLS         = 32,
  parameter int unsigned JOY_INTERVAL = 1_000_000,
  parameter int unsigned TIMEOUT_CYC  = 2_000_000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [16*NUM_PADS-1:0] joy_in,
  output logic [16*NUM_PADS-1:0] hid_out,
  output logic [31:0]           core_config,
  output logic                  overlay,
  output logic [7:0]            rom_loading,
  output logic [7:0]            rom_do,
  output logic                  rom_do_valid,
  output logic                  char_we,
  output logic [7:0]            char_x,
  output logic [7:0]            char_y,
  output logic [7:0]            char_d,
  output logic                  err_timeout
);

  localparam int unsigned LEN_W = 8 * LEN_BYTES;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned JT_W  = $clog2(JOY_INTERVAL + 1);

  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [JT_W-1:0] JOY_RELOAD = JT_W'(JOY_INTERVAL);
  localparam logic [3:0]      HID_LAST   = 4'(2 * NUM_PADS - 1);
  localparam logic [3:0]      LEN_LAST   = 4'(LEN_BYTES - 1);
  localparam logic [3:0]      JOY_LAST   = 4'(2 * NUM_PADS);

  typedef enum logic [2:0] {
    RX_IDLE, RX_PARAM, RX_ROM_LEN, RX_ROM_DATA, RX_ROM_SUM
  } rx_state_t;

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  // RX side
  rx_state_t            r_rx_state, w_rx_next;
  logic [7:0]           r_cmd;
  logic [3:0]           r_cnt;
  logic [23:0]          r_buf;
  logic [LEN_W-1:0]     r_left;
  logic [LEN_W-1:0]     w_len_full;
  logic [7:0]           r_sum;
  logic [TO_W-1:0]      r_to_cnt;
  logic                 w_timeout;
  logic [7:0]           r_cur_x, r_cur_y;

  // Response queue (depth 1)
  logic                 r_resp_pend, r_resp_rom, r_resp_bad;
  logic                 w_resp_set, w_resp_rom, w_resp_bad;

  // TX side
  tx_state_t            r_tx_state, w_tx_next;
  logic                 w_take_resp, w_take_joy;
  logic [7:0]           r_frame [16];
  logic [3:0]           r_tx_idx, r_tx_last;
  logic [16*NUM_PADS-1:0] r_shadow;
  logic [JT_W-1:0]      r_joy_timer;

  // Registered outputs
  logic [16*NUM_PADS-1:0] r_hid;
  logic [31:0]          r_core_config;
  logic                 r_overlay;
  logic [7:0]           r_rom_loading, r_rom_do;
  logic                 r_rom_do_valid, r_char_we, r_err_timeout;
  logic [7:0]           r_char_x, r_char_y, r_char_d;

  // ---------------- RX next state ----------------
  always_comb begin
    w_rx_next  = r_rx_state;
    w_timeout  = 1'b0;
    w_resp_set = 1'b0;
    w_resp_rom = 1'b0;
    w_resp_bad = 1'b0;
    w_len_full = {r_left[LEN_W-9:0], rx_data};
    if (r_rx_state != RX_IDLE && !rx_valid && r_to_cnt == TO_LAST) begin
      w_timeout = 1'b1;
      w_rx_next = RX_IDLE;
    end else if (rx_valid) begin
      case (r_rx_state)
        RX_IDLE: begin
          case (rx_data)
            8'h01: w_resp_set = 1'b1;
            8'h03, 8'h04, 8'h05, 8'h06, 8'h08, 8'h09: w_rx_next = RX_PARAM;
            8'h07: w_rx_next = RX_ROM_LEN;
            default: w_rx_next = RX_IDLE;
          endcase
        end
        RX_PARAM: begin
          case (r_cmd)
            8'h03: if (r_cnt == 4'd3) w_rx_next = RX_IDLE;
            8'h04: if (r_cnt == 4'd1) w_rx_next = RX_IDLE;
            8'h05: if (rx_data == 8'h00) w_rx_next = RX_IDLE;
            8'h09: if (r_cnt == HID_LAST) w_rx_next = RX_IDLE;
            default: w_rx_next = RX_IDLE;
          endcase
        end
        RX_ROM_LEN: begin
          if (r_cnt == LEN_LAST)
            w_rx_next = (w_len_full == '0) ? RX_ROM_SUM : RX_ROM_DATA;
        end
        RX_ROM_DATA: begin
          if (r_left == LEN_W'(1)) w_rx_next = RX_ROM_SUM;
        end
        RX_ROM_SUM: begin
          w_resp_set = 1'b1;
          w_resp_rom = 1'b1;
          w_resp_bad = (rx_data != r_sum);
          w_rx_next  = RX_IDLE;
        end
        default: w_rx_next = RX_IDLE;
      endcase
    end
  end

  // ---------------- RX datapath ----------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rx_state     <= RX_IDLE;
      r_cmd          <= '0;
      r_cnt          <= '0;
      r_buf          <= '0;
      r_left         <= '0;
      r_sum          <= '0;
      r_to_cnt       <= '0;
      r_cur_x        <= '0;
      r_cur_y        <= '0;
      r_resp_pend    <= 1'b0;
      r_resp_rom     <= 1'b0;
      r_resp_bad     <= 1'b0;
      r_hid          <= '0;
      r_core_config  <= '0;
      r_overlay      <= 1'b1;
      r_rom_loading  <= '0;
      r_rom_do       <= '0;
      r_rom_do_valid <= 1'b0;
      r_char_we      <= 1'b0;
      r_char_x       <= '0;
      r_char_y       <= '0;
      r_char_d       <= '0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_rx_state     <= w_rx_next;
      r_err_timeout  <= w_timeout;
      r_rom_do_valid <= 1'b0;
      r_char_we      <= 1'b0;

      if (r_rx_state == RX_IDLE || rx_valid) r_to_cnt <= '0;
      else                                   r_to_cnt <= r_to_cnt + TO_W'(1);

      // A fresh response overwrites a pending one; TX has already copied
      // anything it is sending, so the frame on the wire is unaffected.
      if (w_resp_set) begin
        r_resp_pend <= 1'b1;
        r_resp_rom  <= w_resp_rom;
        r_resp_bad  <= w_resp_bad;
      end else if (w_take_resp) begin
        r_resp_pend <= 1'b0;
      end

      // Multi-byte fields are staged in r_buf and committed only on the
      // final byte, so a timeout never leaves a half-written register.
      if (rx_valid) begin
        case (r_rx_state)
          RX_IDLE: begin
            r_cmd  <= rx_data;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_left <= '0;
          end
          RX_PARAM: begin
            r_cnt <= r_cnt + 4'd1;
            case (r_cmd)
              8'h03: begin
                r_buf <= {r_buf[15:0], rx_data};
                if (r_cnt == 4'd3) r_core_config <= {r_buf, rx_data};
              end
              8'h04: begin
                if (r_cnt == 4'd0) begin
                  r_buf[7:0] <= rx_data;
                end else begin
                  r_cur_x <= r_buf[7:0];
                  r_cur_y <= rx_data;
                end
              end
              8'h05: begin
                if (rx_data != 8'h00 && 32'(r_cur_x) < COLS) begin
                  r_char_we <= 1'b1;
                  r_char_x  <= r_cur_x;
                  r_char_y  <= r_cur_y;
                  r_char_d  <= rx_data;
                  r_cur_x   <= r_cur_x + 8'd1;
                end
              end
              8'h06: r_rom_loading <= rx_data;
              8'h08: r_overlay     <= rx_data[0];
              8'h09: begin
                if (!r_cnt[0]) begin
                  r_buf[7:0] <= rx_data;
                end else begin
                  for (int unsigned k = 0; k < NUM_PADS; k++) begin
                    if (r_cnt[3:1] == 3'(k)) r_hid[16*k +: 16] <= {rx_data, r_buf[7:0]};
                  end
                end
              end
              default: ;
            endcase
          end
          RX_ROM_LEN: begin
            r_cnt  <= r_cnt + 4'd1;
            r_left <= w_len_full;
          end
          RX_ROM_DATA: begin
            r_rom_do       <= rx_data;
            r_rom_do_valid <= 1'b1;
            r_sum          <= r_sum + rx_data;
            r_left         <= r_left - LEN_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- TX next state ----------------
  always_comb begin
    w_tx_next   = r_tx_state;
    w_take_resp = 1'b0;
    w_take_joy  = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (r_resp_pend) begin
          w_take_resp = 1'b1;
          w_tx_next   = TX_SEND;
        end else if (r_joy_timer == '0 && joy_in != r_shadow) begin
          w_take_joy = 1'b1;
          w_tx_next  = TX_SEND;
        end
      end
      TX_SEND: begin
        if (tx_ready && r_tx_idx == r_tx_last) w_tx_next = TX_IDLE;
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  // ---------------- TX datapath ----------------
  // The whole frame is captured when TX leaves IDLE, which is what keeps
  // frames atomic against later responses and pad changes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tx_state  <= TX_IDLE;
      r_tx_idx    <= '0;
      r_tx_last   <= '0;
      r_shadow    <= '1;
      r_joy_timer <= '0;
      for (int unsigned i = 0; i < 16; i++) r_frame[i] <= '0;
    end else begin
      r_tx_state <= w_tx_next;

      if (w_take_joy)              r_joy_timer <= JOY_RELOAD;
      else if (r_joy_timer != '0)  r_joy_timer <= r_joy_timer - JT_W'(1);

      if (w_take_resp) begin
        r_tx_idx   <= '0;
        r_frame[0] <= r_resp_rom ? 8'h33 : 8'h11;
        r_frame[1] <= r_resp_rom ? {7'd0, r_resp_bad} : CORE_ID[7:0];
        r_frame[2] <= CORE_ID[15:8];
        r_tx_last  <= r_resp_rom ? 4'd1 : 4'd2;
      end else if (w_take_joy) begin
        r_tx_idx   <= '0;
        r_frame[0] <= 8'h01;
        for (int unsigned k = 0; k < NUM_PADS; k++) begin
          r_frame[1 + 2*k] <= joy_in[16*k +: 8];
          r_frame[2 + 2*k] <= joy_in[16*k + 8 +: 8];
        end
        r_tx_last  <= JOY_LAST;
        r_shadow   <= joy_in;
      end else if (r_tx_state == TX_SEND && tx_ready && r_tx_idx != r_tx_last) begin
        r_tx_idx <= r_tx_idx + 4'd1;
      end
    end
  end

  assign tx_valid     = (r_tx_state == TX_SEND);
  assign tx_data      = tx_valid ? r_frame[r_tx_idx] : '0;
  assign hid_out      = r_hid;
  assign core_config  = r_core_config;
  assign overlay      = r_overlay;
  assign rom_loading  = r_rom_loading;
  assign rom_do       = r_rom_do;
  assign rom_do_valid = r_rom_do_valid;
  assign char_we      = r_char_we;
  assign char_x       = r_char_x;
  assign char_y       = r_char_y;
  assign char_d       = r_char_d;
  assign err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_iosys_cmd_engine.sv
module tb_iosys_cmd_engine;

  localparam int NP = 2;
  localparam int JI = 300;
  localparam int TO = 200;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic [16*NP-1:0] joy_in = '1;
  logic [16*NP-1:0] hid_out;
  logic [31:0]   core_config;
  logic          overlay;
  logic [7:0]    rom_loading, rom_do;
  logic          rom_do_valid, char_we, err_timeout;
  logic [7:0]    char_x, char_y, char_d;

  int errors = 0;
  int checks = 0;

  iosys_cmd_engine #(
    .NUM_PADS(NP), .LEN_BYTES(3), .CORE_ID(16'h0001), .COLS(32),
    .JOY_INTERVAL(JI), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .joy_in(joy_in), .hid_out(hid_out), .core_config(core_config),
    .overlay(overlay), .rom_loading(rom_loading), .rom_do(rom_do),
    .rom_do_valid(rom_do_valid), .char_we(char_we), .char_x(char_x),
    .char_y(char_y), .char_d(char_d), .err_timeout(err_timeout)
  );

  initial forever #5 clk = ~clk;

  // Observation queues filled at negedge
  logic [7:0]  tx_q[$];
  int          tx_cyc[$];
  logic [7:0]  rom_q[$];
  logic [23:0] chr_q[$];
  int          to_pulses = 0;
  int          cyc = 0;
  int          stall_seen = 0;
  int          stall_bad = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (tx_valid && tx_ready) begin
      tx_q.push_back(tx_data);
      tx_cyc.push_back(cyc);
    end
    if (prev_stall) begin
      stall_seen++;
      if (!tx_valid || tx_data !== prev_data) stall_bad++;
    end
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
    if (rom_do_valid) rom_q.push_back(rom_do);
    if (char_we) chr_q.push_back({char_x, char_y, char_d});
    if (err_timeout) to_pulses++;
  end

  // tx_ready modes: 0 always ready, 1 stall each byte, 2 never ready
  int rdy_mode = 0;
  int stall_cnt = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: tx_ready = 1'b1;
      2: tx_ready = 1'b0;
      default: begin
        if (tx_ready) tx_ready = 1'b0;
        else if (tx_valid) begin
          stall_cnt++;
          if (stall_cnt == 5) begin
            tx_ready = 1'b1;
            stall_cnt = 0;
          end
        end
      end
    endcase
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (tx_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(3);
    checks++; if (overlay !== 1'b1) begin errors++; $display("FAIL reset_overlay: got %b expected 1", overlay); end
    checks++; if (hid_out !== '0) begin errors++; $display("FAIL reset_hid: got %h expected 0", hid_out); end
    checks++; if (core_config !== 32'h0) begin errors++; $display("FAIL reset_config: got %h expected 0", core_config); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_txvalid: got %b expected 0", tx_valid); end
    checks++; if ({rom_loading, rom_do_valid, char_we, err_timeout} !== 11'h0) begin
      errors++; $display("FAIL reset_misc: got %h expected 0", {rom_loading, rom_do_valid, char_we, err_timeout});
    end
    resetn = 1'b1;
    tick(2);
  endtask

  task automatic test_core_id();
    logic [7:0] exp_q[$];
    logic [7:0] got;
    tx_q.delete();
    exp_q = '{8'h11, 8'h01, 8'h00};
    send_byte(8'h01);
    wait_tx(3, 50);
    tick(20);
    checks++; if (tx_q.size() != 3) begin errors++; $display("FAIL core_id_len: got %0d expected 3", tx_q.size()); end
    for (int i = 0; i < int'(exp_q.size()); i++) begin
      got = (i < int'(tx_q.size())) ? tx_q[i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL core_id_b%0d: got %h expected %h", i, got, exp_q[i]); end
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL core_id_idle: got %b expected 0", tx_valid); end
  endtask

  task automatic test_hid();
    send_byte(8'h09);
    send_byte(8'h34);
    checks++; if (hid_out !== 32'h0) begin errors++; $display("FAIL hid_lo0: got %h expected 00000000", hid_out); end
    send_byte(8'h12);
    checks++; if (hid_out !== 32'h0000_1234) begin errors++; $display("FAIL hid_hi0: got %h expected 00001234", hid_out); end
    send_byte(8'h78);
    checks++; if (hid_out !== 32'h0000_1234) begin errors++; $display("FAIL hid_lo1: got %h expected 00001234", hid_out); end
    send_byte(8'h56);
    checks++; if (hid_out !== 32'h5678_1234) begin errors++; $display("FAIL hid_hi1: got %h expected 56781234", hid_out); end
  endtask

  task automatic test_rom();
    logic [7:0] seq[$];
    logic [7:0] rexp[$];
    logic [7:0] got;
    rexp = '{8'h10, 8'h20, 8'h30};
    for (int pass = 0; pass < 3; pass++) begin
      tx_q.delete();
      rom_q.delete();
      if (pass == 0)      seq = '{8'h07, 8'h00, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30, 8'h60};
      else if (pass == 1) seq = '{8'h07, 8'h00, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30, 8'h61};
      else                seq = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00};
      foreach (seq[i]) send_byte(seq[i]);
      wait_tx(2, 50);
      tick(10);
      checks++;
      if (tx_q.size() != 2) begin errors++; $display("FAIL rom%0d_txlen: got %0d expected 2", pass, tx_q.size()); end
      got = (tx_q.size() > 0) ? tx_q[0] : 8'hxx;
      checks++; if (got !== 8'h33) begin errors++; $display("FAIL rom%0d_hdr: got %h expected 33", pass, got); end
      got = (tx_q.size() > 1) ? tx_q[1] : 8'hxx;
      checks++;
      if (got !== ((pass == 1) ? 8'h01 : 8'h00)) begin
        errors++; $display("FAIL rom%0d_status: got %h expected %h", pass, got, (pass == 1) ? 8'h01 : 8'h00);
      end
      checks++;
      if (rom_q.size() != ((pass == 2) ? 0 : 3)) begin
        errors++; $display("FAIL rom%0d_count: got %0d expected %0d", pass, rom_q.size(), (pass == 2) ? 0 : 3);
      end
      if (pass != 2) begin
        for (int i = 0; i < 3; i++) begin
          got = (i < int'(rom_q.size())) ? rom_q[i] : 8'hxx;
          checks++;
          if (got !== rexp[i]) begin errors++; $display("FAIL rom%0d_data%0d: got %h expected %h", pass, i, got, rexp[i]); end
        end
      end
    end
  endtask

  task automatic test_text();
    logic [23:0] cexp[$];
    logic [23:0] got;
    logic [7:0] seq[$];
    cexp = '{24'h1E0241, 24'h1F0242};
    seq  = '{8'h04, 8'h1E, 8'h02, 8'h05, 8'h41, 8'h42, 8'h43, 8'h44, 8'h00};
    chr_q.delete();
    foreach (seq[i]) send_byte(seq[i]);
    tick(5);
    checks++; if (chr_q.size() != 2) begin errors++; $display("FAIL text_count: got %0d expected 2", chr_q.size()); end
    for (int i = 0; i < 2; i++) begin
      got = (i < int'(chr_q.size())) ? chr_q[i] : 24'hxxxxxx;
      checks++;
      if (got !== cexp[i]) begin errors++; $display("FAIL text_w%0d: got %h expected %h", i, got, cexp[i]); end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] seq[$];
    seq = '{8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    foreach (seq[i]) send_byte(seq[i]);
    checks++; if (core_config !== 32'hDEAD_BEEF) begin errors++; $display("FAIL cfg_set: got %h expected deadbeef", core_config); end
    to_pulses = 0;
    send_byte(8'h03);
    send_byte(8'hAA);
    send_byte(8'hBB);
    tick(TO - 20);
    checks++; if (to_pulses != 0) begin errors++; $display("FAIL to_early: got %0d expected 0", to_pulses); end
    tick(40);
    checks++; if (to_pulses != 1) begin errors++; $display("FAIL to_pulse: got %0d expected 1", to_pulses); end
    checks++; if (core_config !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_cfg: got %h expected deadbeef", core_config); end
    send_byte(8'h08);
    send_byte(8'h00);
    checks++; if (overlay !== 1'b0) begin errors++; $display("FAIL to_overlay: got %b expected 0", overlay); end
    tick(TO + 20);
    checks++; if (to_pulses != 1) begin errors++; $display("FAIL to_idle: got %0d expected 1", to_pulses); end
    checks++; if (core_config !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_cfg2: got %h expected deadbeef", core_config); end
  endtask

  task automatic test_joy_stall();
    logic [7:0] exp_q[$];
    logic [7:0] got;
    int gap;
    rdy_mode = 1;
    tick(3);
    tx_q.delete();
    tx_cyc.delete();
    stall_seen = 0;
    stall_bad = 0;
    exp_q = '{8'h01, 8'h34, 8'h12, 8'hA5, 8'hA5, 8'h11, 8'h01, 8'h00,
              8'h01, 8'h01, 8'h80, 8'h0F, 8'h0F};
    joy_in = 32'hA5A5_1234;
    tick(10);
    send_byte(8'h01);
    tick(10);
    joy_in = 32'h0F0F_8001;
    wait_tx(13, 1500);
    tick(20);
    rdy_mode = 0;
    checks++; if (tx_q.size() != 13) begin errors++; $display("FAIL joy_len: got %0d expected 13", tx_q.size()); end
    for (int i = 0; i < 13; i++) begin
      got = (i < int'(tx_q.size())) ? tx_q[i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL joy_b%0d: got %h expected %h", i, got, exp_q[i]); end
    end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL joy_stable: got %0d unstable stalls expected 0", stall_bad); end
    checks++; if (stall_seen < 20) begin errors++; $display("FAIL joy_stalled: got %0d stall cycles expected >=20", stall_seen); end
    gap = (tx_cyc.size() > 8) ? tx_cyc[8] - tx_cyc[0] : 0;
    checks++; if (gap < JI - 6) begin errors++; $display("FAIL joy_rate: got gap %0d expected >= %0d", gap, JI - 6); end
  endtask

  task automatic test_overwrite();
    logic [7:0] exp_q[$];
    logic [7:0] got;
    logic [7:0] seq[$];
    rdy_mode = 2;
    tick(2);
    tx_q.delete();
    exp_q = '{8'h11, 8'h01, 8'h00, 8'h33, 8'h01};
    seq = '{8'h01, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h01};
    foreach (seq[i]) send_byte(seq[i]);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h11) begin
      errors++; $display("FAIL ow_hold: got valid=%b data=%h expected valid=1 data=11", tx_valid, tx_data);
    end
    rdy_mode = 0;
    wait_tx(5, 100);
    tick(20);
    checks++; if (tx_q.size() != 5) begin errors++; $display("FAIL ow_len: got %0d expected 5", tx_q.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < int'(tx_q.size())) ? tx_q[i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL ow_b%0d: got %h expected %h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] exp_q[$];
    logic [7:0] got;
    logic [7:0] seq[$];
    joy_in = '1;
    rdy_mode = 2;
    tick(2);
    rom_q.delete();
    seq = '{8'h01, 8'h07, 8'h00, 8'h00, 8'h02, 8'hAA};
    foreach (seq[i]) send_byte(seq[i]);
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL rst_pre: got valid=%b expected 1", tx_valid); end
    resetn = 1'b0;
    tick(1);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_txdrop: got %b expected 0", tx_valid); end
    checks++; if (overlay !== 1'b1) begin errors++; $display("FAIL rst_overlay: got %b expected 1", overlay); end
    checks++; if (core_config !== 32'h0 || hid_out !== '0) begin
      errors++; $display("FAIL rst_regs: got cfg=%h hid=%h expected 0", core_config, hid_out);
    end
    resetn = 1'b1;
    rdy_mode = 0;
    tick(2);
    tx_q.delete();
    exp_q = '{8'h11, 8'h01, 8'h00};
    send_byte(8'h01);
    wait_tx(3, 50);
    tick(10);
    checks++; if (tx_q.size() != 3) begin errors++; $display("FAIL rst_after_len: got %0d expected 3", tx_q.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < int'(tx_q.size())) ? tx_q[i] : 8'hxx;
      checks++;
      if (got !== exp_q[i]) begin errors++; $display("FAIL rst_after_b%0d: got %h expected %h", i, got, exp_q[i]); end
    end
    checks++; if (rom_q.size() != 1) begin errors++; $display("FAIL rst_rom: got %0d rom bytes expected 1", rom_q.size()); end
  endtask

  initial begin
    test_reset();
    test_core_id();
    test_hid();
    test_rom();
    test_text();
    test_timeout();
    test_joy_stall();
    test_overwrite();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
